// File: rtl/sdram_tester_if.sv
// Request bus between the SDRAM tester (master) and the SDRAM controller (slave).
interface sdram_tester_if #(
  parameter int addrBits = 24,
  parameter int dataBits = 16
);
  logic [addrBits-1:0] addr;
  logic                r;
  logic                w;
  logic [dataBits-1:0] dw;
  logic [dataBits-1:0] dr;
  logic                busy;

  modport master (output addr, r, w, dw, input dr, busy);
  modport slave  (input addr, r, w, dw, output dr, busy);
endinterface

// File: rtl/sdram_tester.sv
// SDRAM bring-up traffic generator: write a pattern over 0..lastAddr, read back, compare.
// Define SDRAM_TESTER_ERRLOG_EN to capture address/expected/got of the first mismatch.
module sdram_tester #(
  parameter int bankBits = 2,
  parameter int rowBits  = 13,
  parameter int colBits  = 9,
  parameter int dataBits = 16,
  parameter logic [bankBits+rowBits+colBits-1:0] lastAddr = '1
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  sdram_tester_if.master                       bus,
  output logic [7:0]                           passes,
  output logic                                 ok,
  output logic                                 fail,
  output logic [bankBits+rowBits+colBits-1:0]  errAddr,
  output logic [dataBits-1:0]                  errExp,
  output logic [dataBits-1:0]                  errGot
);
  localparam int addrBits = bankBits + rowBits + colBits;
  localparam int extBits  = addrBits + 2*dataBits;

  typedef enum logic [2:0] {
    START, WR_REQ, WR_ACK, WR_WAIT, RD_REQ, RD_ACK, RD_WAIT, HALT
  } state_t;

  state_t              state;
  logic                p;
  logic                at_last;
  logic                rd_done;
  logic                mismatch;
  logic [addrBits-1:0] addr_inc;
  logic [dataBits-1:0] exp_rd;
  logic [dataBits-1:0] exp_nxt;

  // Low word xor next word up; anything above 2*dataBits is dropped on purpose.
  function automatic logic [dataBits-1:0] pattern(input logic [addrBits-1:0] a, input logic par);
    logic [extBits-1:0] ext;
    ext = extBits'(a);
    ext = ext ^ (ext >> dataBits);
    return ext[dataBits-1:0] ^ {dataBits{par}};
  endfunction

  assign p        = passes[0];
  assign at_last  = (bus.addr == lastAddr);
  assign addr_inc = bus.addr + addrBits'(1);
  assign exp_rd   = pattern(bus.addr, p);
  assign exp_nxt  = pattern(addr_inc, p);
  assign rd_done  = (state == RD_WAIT) && !bus.busy;
  assign mismatch = (bus.dr != exp_rd);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= START;
      bus.addr <= '0;
      bus.r    <= 1'b0;
      bus.w    <= 1'b0;
      bus.dw   <= '0;
      passes   <= '0;
      ok       <= 1'b0;
      fail     <= 1'b0;
    end else begin
      case (state)
        // Also covers a reset that landed while the controller was mid-operation.
        START: if (!bus.busy) begin
          bus.addr <= '0;
          bus.w    <= 1'b1;
          bus.dw   <= pattern('0, p);
          state    <= WR_REQ;
        end
        WR_REQ: if (!bus.busy) begin
          bus.w <= 1'b0;
          state <= WR_ACK;
        end
        WR_ACK: state <= WR_WAIT;
        WR_WAIT: if (!bus.busy) begin
          if (at_last) begin
            bus.addr <= '0;
            bus.r    <= 1'b1;
            state    <= RD_REQ;
          end else begin
            bus.addr <= addr_inc;
            bus.w    <= 1'b1;
            bus.dw   <= exp_nxt;
            state    <= WR_REQ;
          end
        end
        RD_REQ: if (!bus.busy) begin
          bus.r <= 1'b0;
          state <= RD_ACK;
        end
        RD_ACK: state <= RD_WAIT;
        RD_WAIT: if (rd_done) begin
          if (mismatch) begin
            fail  <= 1'b1;
            state <= HALT;
          end else if (at_last) begin
            passes <= passes + 8'd1;
            ok     <= ~ok;
            state  <= START;
          end else begin
            bus.addr <= addr_inc;
            bus.r    <= 1'b1;
            state    <= RD_REQ;
          end
        end
        HALT: begin
          bus.r <= 1'b0;
          bus.w <= 1'b0;
          fail  <= 1'b1;
        end
        default: state <= START;
      endcase
    end
  end

`ifdef SDRAM_TESTER_ERRLOG_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      errAddr <= '0;
      errExp  <= '0;
      errGot  <= '0;
    end else if (rd_done && mismatch && !fail) begin
      errAddr <= bus.addr;
      errExp  <= exp_rd;
      errGot  <= bus.dr;
    end
  end
`else
  assign errAddr = '0;
  assign errExp  = '0;
  assign errGot  = '0;
`endif

  a_excl: assert property (@(posedge clk) disable iff (!rstn) !(bus.r && bus.w));
  a_range: assert property (@(posedge clk) disable iff (!rstn) bus.addr <= lastAddr);
  a_rd_hold: assert property (@(posedge clk) disable iff (!rstn)
    (bus.r && bus.busy) |=> (bus.r && $stable(bus.addr)));
  a_wr_hold: assert property (@(posedge clk) disable iff (!rstn)
    (bus.w && bus.busy) |=> (bus.w && $stable(bus.addr) && $stable(bus.dw)));
  a_gap: assert property (@(posedge clk) disable iff (!rstn)
    ((bus.r || bus.w) && !bus.busy) |=> !(bus.r || bus.w));
  a_halt: assert property (@(posedge clk) disable iff (!rstn)
    (state == HALT) |=> (state == HALT && fail));
endmodule

// File: tb/tb_sdram_tester.sv
// Bench: two testers (lastAddr=7 and lastAddr=0) against behavioural controllers, scoreboarded.
module tb_sdram_tester;
  localparam int AB = 24;
  localparam int DB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn = 1'b0;
  logic rstn1 = 1'b0;

  sdram_tester_if #(.addrBits(AB), .dataBits(DB)) bus0 ();
  sdram_tester_if #(.addrBits(AB), .dataBits(DB)) bus1 ();

  logic [7:0]    passes0, passes1;
  logic          ok0, ok1, fail0, fail1;
  logic [AB-1:0] err_addr0, err_addr1;
  logic [DB-1:0] err_exp0, err_got0, err_exp1, err_got1;

  sdram_tester #(.lastAddr(24'd7)) dut0 (
    .clk(clk), .rstn(rstn), .bus(bus0), .passes(passes0), .ok(ok0), .fail(fail0),
    .errAddr(err_addr0), .errExp(err_exp0), .errGot(err_got0));

  sdram_tester #(.lastAddr(24'd0)) dut1 (
    .clk(clk), .rstn(rstn1), .bus(bus1), .passes(passes1), .ok(ok1), .fail(fail1),
    .errAddr(err_addr1), .errExp(err_exp1), .errGot(err_got1));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Controller model 0: 10 busy cycles after reset, 3 busy cycles per op, extra stalls.
  int cyc = 0;
  int init_until = 0;
  int hold_until = 0;
  int hold2_until = 0;
  int op0 = 0;
  logic freeze = 1'b0;
  logic corrupt_en = 1'b0;
  logic [DB-1:0] mem0 [8];
  logic [DB-1:0] dr0 = '0;

  assign bus0.busy = (op0 != 0) || (cyc < init_until) || (cyc < hold_until) ||
                     (cyc < hold2_until) || freeze;
  assign bus0.dr = dr0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rstn) begin
      op0 <= 0;
      init_until <= cyc + 11;
    end else if (op0 != 0) begin
      op0 <= op0 - 1;
    end else if ((bus0.r || bus0.w) && !bus0.busy) begin
      op0 <= 3;
      if (bus0.w) mem0[bus0.addr[2:0]] <= bus0.dw;
      else dr0 <= (corrupt_en && passes0 == 8'd1 && bus0.addr == 24'd3) ? '0 : mem0[bus0.addr[2:0]];
    end
  end

  // Controller model 1: plain 3-cycle ops, single word.
  int op1 = 0;
  logic [DB-1:0] mem1 = '0;
  logic [DB-1:0] dr1 = '0;
  assign bus1.busy = (op1 != 0);
  assign bus1.dr = dr1;

  always @(posedge clk) begin
    if (!rstn1) op1 <= 0;
    else if (op1 != 0) op1 <= op1 - 1;
    else if (bus1.r || bus1.w) begin
      op1 <= 3;
      if (bus1.w) mem1 <= bus1.dw;
      else dr1 <= mem1;
    end
  end

  typedef struct {
    bit            rd;
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
    int            pass;
  } req_t;
  req_t exp_q[$];

  // For addresses below 2^16 the pattern is just the address, inverted on odd passes.
  function automatic logic [DB-1:0] exp_word(input int a, input int pass);
    logic [DB-1:0] v;
    v = DB'(a);
    return (pass % 2 == 1) ? ~v : v;
  endfunction

  task automatic push_pass(input int pass, input int n_rd);
    for (int a = 0; a < 8; a++) exp_q.push_back('{1'b0, AB'(a), exp_word(a, pass), pass});
    for (int a = 0; a < n_rd; a++) exp_q.push_back('{1'b1, AB'(a), exp_word(a, pass), pass});
  endtask

  logic mon_en = 1'b0;
  logic stall_arm = 1'b0;
  logic stall_done = 1'b0;
  logic stall_on = 1'b0;
  logic [AB-1:0] st_addr;
  logic [DB-1:0] st_dw;
  int stall_bad = 0;

  logic exp1_rd = 1'b0;
  logic exp1_p = 1'b0;
  int rd1_cnt = 0;
  int seen1_cnt = 0;
  logic [7:0] seen_p1 = '0;

  always @(negedge clk) begin : monitor
    req_t e;
    bit trig;
    trig = 1'b0;
    if (mon_en) begin
      if (stall_arm && !stall_done && bus0.r && bus0.addr == 24'd2) begin
        stall_done = 1'b1;
        stall_on = 1'b1;
        trig = 1'b1;
        hold_until = cyc + 50;
        st_addr = bus0.addr;
        st_dw = bus0.dw;
      end else if (stall_on) begin
        if (!bus0.r || bus0.addr != st_addr || bus0.dw != st_dw) stall_bad++;
        if (cyc >= hold_until) begin
          stall_on = 1'b0;
          check("stall_stable", 32'(stall_bad), 32'd0);
        end
      end
      if (!trig && (bus0.r || bus0.w) && !bus0.busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_req r=%0b w=%0b addr=%h required=none", bus0.r, bus0.w, bus0.addr);
        end else begin
          e = exp_q.pop_front();
          check("req_kind", 32'(bus0.r), 32'(e.rd));
          check("req_addr", 32'(bus0.addr), 32'(e.addr));
          check("req_excl", 32'(bus0.r & bus0.w), 32'd0);
          if (!e.rd) check("req_dw", 32'(bus0.dw), 32'(e.data));
          if (!e.rd && e.addr == 24'd5 && e.pass == 0) check("dw_a5_p0", 32'(bus0.dw), 32'h0005);
          if (!e.rd && e.addr == 24'd5 && e.pass == 1) check("dw_a5_p1", 32'(bus0.dw), 32'hFFFA);
        end
      end
    end
    if (rd1_cnt < 6 && (bus1.r || bus1.w) && !bus1.busy) begin
      check("l0_kind", 32'(bus1.r), 32'(exp1_rd));
      check("l0_addr", 32'(bus1.addr), 32'd0);
      if (!exp1_rd) check("l0_dw", 32'(bus1.dw), exp1_p ? 32'hFFFF : 32'h0);
      if (exp1_rd) begin
        rd1_cnt++;
        exp1_p = ~exp1_p;
      end
      exp1_rd = ~exp1_rd;
    end
    if (passes1 != seen_p1 && seen1_cnt < 6) begin
      check("l0_passes", 32'(passes1), 32'(rd1_cnt));
      seen_p1 = passes1;
      seen1_cnt++;
    end
  end

  initial begin : main
    int toggles;
    int early;
    logic prev_ok;

    repeat (3) @(negedge clk);
    check("rst_addr", 32'(bus0.addr), 32'd0);
    check("rst_r", 32'(bus0.r), 32'd0);
    check("rst_w", 32'(bus0.w), 32'd0);
    check("rst_dw", 32'(bus0.dw), 32'd0);
    check("rst_passes", 32'(passes0), 32'd0);
    check("rst_ok", 32'(ok0), 32'd0);
    check("rst_fail", 32'(fail0), 32'd0);
    check("rst_err_addr", 32'(err_addr0), 32'd0);
    check("rst_err_exp", 32'(err_exp0), 32'd0);
    check("rst_err_got", 32'(err_got0), 32'd0);

    // Three clean passes with a 50-cycle stall on the pass-0 read of address 2.
    push_pass(0, 8);
    push_pass(1, 8);
    push_pass(2, 8);
    mon_en = 1'b1;
    stall_arm = 1'b1;
    rstn = 1'b1;
    rstn1 = 1'b1;
    toggles = 0;
    prev_ok = ok0;
    for (int i = 0; i < 6000 && passes0 != 8'd3; i++) begin
      @(negedge clk);
      if (ok0 != prev_ok) begin
        toggles++;
        prev_ok = ok0;
      end
    end
    freeze = 1'b1;
    check("passes_3", 32'(passes0), 32'd3);
    check("ok_toggles", 32'(toggles), 32'd3);
    check("ok_level", 32'(ok0), 32'd1);
    check("fail_clean", 32'(fail0), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("stall_hit", 32'(stall_done), 32'd1);

    // Corrupted read of address 3 in pass 1.
    rstn = 1'b0;
    freeze = 1'b0;
    corrupt_en = 1'b1;
    repeat (2) @(negedge clk);
    push_pass(0, 8);
    push_pass(1, 4);
    rstn = 1'b1;
    for (int i = 0; i < 4000 && !fail0; i++) @(negedge clk);
    check("fail_set", 32'(fail0), 32'd1);
    check("fail_passes", 32'(passes0), 32'd1);
    repeat (30) @(negedge clk);
    check("halt_r", 32'(bus0.r), 32'd0);
    check("halt_w", 32'(bus0.w), 32'd0);
    check("halt_fail", 32'(fail0), 32'd1);
    check("halt_queue", 32'(exp_q.size()), 32'd0);
`ifdef SDRAM_TESTER_ERRLOG_EN
    check("err_addr", 32'(err_addr0), 32'd3);
    check("err_exp", 32'(err_exp0), 32'hFFFC);
    check("err_got", 32'(err_got0), 32'h0000);
`else
    check("err_addr", 32'(err_addr0), 32'd0);
    check("err_exp", 32'(err_exp0), 32'd0);
    check("err_got", 32'(err_got0), 32'd0);
`endif

    // One-cycle reset while a write is pending and the controller is busy.
    mon_en = 1'b0;
    corrupt_en = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 200 && !bus0.w; i++) @(negedge clk);
    check("mid_w_seen", 32'(bus0.w), 32'd1);
    hold2_until = cyc + 20;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("mid_w", 32'(bus0.w), 32'd0);
    check("mid_r", 32'(bus0.r), 32'd0);
    check("mid_addr", 32'(bus0.addr), 32'd0);
    check("mid_dw", 32'(bus0.dw), 32'd0);
    check("mid_passes", 32'(passes0), 32'd0);
    check("mid_ok", 32'(ok0), 32'd0);
    check("mid_fail", 32'(fail0), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    early = 0;
    for (int i = 0; i < 100 && bus0.busy; i++) begin
      @(negedge clk);
      if (bus0.busy && (bus0.r || bus0.w)) early++;
    end
    check("busy_released", 32'(bus0.busy), 32'd0);
    check("no_req_while_busy", 32'(early), 32'd0);
    for (int i = 0; i < 10 && !bus0.w; i++) @(negedge clk);
    check("restart_w", 32'(bus0.w), 32'd1);
    check("restart_addr", 32'(bus0.addr), 32'd0);
    check("restart_dw", 32'(bus0.dw), 32'd0);

    check("l0_reads", 32'(rd1_cnt), 32'd6);
    check("l0_pass_events", 32'(seen1_cnt), 32'd6);
    check("l0_fail", 32'(fail1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
